// File: rtl/ff2_sync_pkg.sv
// ff2_sync_pkg
//   Shared constants and helpers for the ff2_sync level synchroniser.
//   STAGES_MIN / STAGES_MAX bound the legal flop-chain depth.
//   stages_legal() is evaluated at elaboration to reject illegal chain depths.
package ff2_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;

    function automatic bit stages_legal(input int stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage : ff2_sync_pkg

// File: rtl/ff2_sync.sv
// ff2_sync
//   Multi-flop synchroniser for level signals entering the clk domain from an
//   unrelated clock.  It also produces single-cycle rise/fall pulses on the
//   synchronised level.  Every flop clocks on the same edge of clk: the
//   rising edge when NEGEDGE=0, the falling edge when NEGEDGE=1.
//
// Parameters
//   WIDTH      number of independent level bits (no cross-bit coherency)
//   STAGES     flop stages in the chain, 2..4
//   NEGEDGE    0: posedge clk, 1: negedge clk
//   RESET_VAL  value loaded into every stage and the edge-detect history flop
//
// Ports
//   clk       in   destination-domain clock
//   reset_n   in   synchronous active-low reset, sampled on the active edge
//   in_async  in   [WIDTH] asynchronous level input
//   out_sync  out  [WIDTH] synchronised level (last chain stage)
//   out_rise  out  [WIDTH] one-cycle pulse when out_sync goes 0->1
//   out_fall  out  [WIDTH] one-cycle pulse when out_sync goes 1->0
module ff2_sync
    import ff2_sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter int               NEGEDGE   = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] out_sync,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall
);

    // Reject an illegal chain depth at elaboration time.
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("ff2_sync: STAGES=%0d outside legal range %0d..%0d",
               STAGES, STAGES_MIN, STAGES_MAX);
    end

    // Chain flops must stay adjacent: no merging, retiming or logic between them.
    (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    // History of out_sync for edge detection.  It resets to RESET_VAL, like the
    // chain, so reset release never produces a spurious pulse.
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            chain_d[i] = RESET_VAL;
        end
        hist_d = RESET_VAL;
        if (reset_n) begin
            chain_d[0] = in_async;
            for (int i = 1; i < STAGES; i++) begin
                chain_d[i] = chain_q[i-1];
            end
            hist_d = chain_q[STAGES-1];
        end
    end

    // The active edge is selected structurally; the clock is never inverted
    // through logic.
    if (NEGEDGE != 0) begin : g_neg
        always_ff @(negedge clk) begin
            chain_q <= chain_d;
            hist_q  <= hist_d;
        end
    end else begin : g_pos
        always_ff @(posedge clk) begin
            chain_q <= chain_d;
            hist_q  <= hist_d;
        end
    end

    // The edge pulses are decoded only from registered values, so they are glitch-free.
    assign out_sync = chain_q[STAGES-1];
    assign out_rise = chain_q[STAGES-1] & ~hist_q;
    assign out_fall = ~chain_q[STAGES-1] & hist_q;

endmodule : ff2_sync

// File: tb/tb_ff2_sync.sv
// tb_ff2_sync
//   Bench for ff2_sync.  It exercises four configurations side by side:
//     u_p2   : WIDTH=1, STAGES=2, posedge, RESET_VAL=0
//     u_n2   : WIDTH=1, STAGES=2, negedge, RESET_VAL=0
//     u_p3w4 : WIDTH=4, STAGES=3, posedge, RESET_VAL=0
//     u_rv1  : WIDTH=1, STAGES=2, posedge, RESET_VAL=1
//   The reference is a per-edge log of sampled inputs and resets.  After edge n,
//   out_sync equals the input sampled at edge n-STAGES+1, unless a reset was
//   seen at any edge in n-STAGES+1..n; in that case it equals RESET_VAL.
module tb_ff2_sync;

    logic       clk;
    logic       reset_n;
    logic       in_a;
    logic [3:0] in_w;

    logic       p2_out, p2_rise, p2_fall;
    logic       n2_out, n2_rise, n2_fall;
    logic [3:0] p3_out, p3_rise, p3_fall;
    logic       rv_out, rv_rise, rv_fall;

    int total = 0;
    int bad   = 0;

    // Per-edge logs: index n is the n-th active edge of that domain.
    logic       p_a   [$];
    logic [3:0] p_w   [$];
    bit         p_rst [$];
    logic       n_a   [$];
    bit         n_rst [$];

    logic n_last_out;
    bit   n_seen = 0;

    bit count_en = 0;
    int p2_rise_cnt = 0, p2_fall_cnt = 0;
    int n2_rise_cnt = 0, n2_fall_cnt = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ff2_sync #(.WIDTH(1), .STAGES(2), .NEGEDGE(0), .RESET_VAL(1'b0)) u_p2 (
        .clk(clk), .reset_n(reset_n), .in_async(in_a),
        .out_sync(p2_out), .out_rise(p2_rise), .out_fall(p2_fall));

    ff2_sync #(.WIDTH(1), .STAGES(2), .NEGEDGE(1), .RESET_VAL(1'b0)) u_n2 (
        .clk(clk), .reset_n(reset_n), .in_async(in_a),
        .out_sync(n2_out), .out_rise(n2_rise), .out_fall(n2_fall));

    ff2_sync #(.WIDTH(4), .STAGES(3), .NEGEDGE(0), .RESET_VAL(4'h0)) u_p3w4 (
        .clk(clk), .reset_n(reset_n), .in_async(in_w),
        .out_sync(p3_out), .out_rise(p3_rise), .out_fall(p3_fall));

    ff2_sync #(.WIDTH(1), .STAGES(2), .NEGEDGE(0), .RESET_VAL(1'b1)) u_rv1 (
        .clk(clk), .reset_n(reset_n), .in_async(in_a),
        .out_sync(rv_out), .out_rise(rv_rise), .out_fall(rv_fall));

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] p_level(input int n, input int s,
                                           input logic [3:0] rv, input bit wide);
        if (n < 0) return rv;
        for (int k = n - s + 1; k <= n; k++) begin
            if (k < 0) return rv;
            if (p_rst[k]) return rv;
        end
        return wide ? p_w[n-s+1] : {3'b000, p_a[n-s+1]};
    endfunction

    function automatic logic [3:0] p_prev(input int n, input int s,
                                          input logic [3:0] rv, input bit wide);
        if (n == 0 || p_rst[n]) return rv;
        return p_level(n - 1, s, rv, wide);
    endfunction

    function automatic logic n_level(input int n);
        if (n < 0) return 1'b0;
        for (int k = n - 1; k <= n; k++) begin
            if (k < 0) return 1'b0;
            if (n_rst[k]) return 1'b0;
        end
        return n_a[n-1];
    endfunction

    function automatic logic n_prev(input int n);
        if (n == 0 || n_rst[n]) return 1'b0;
        return n_level(n - 1);
    endfunction

    // ---------------- compare: posedge domain ----------------
    always @(posedge clk) begin
        int n;
        logic [3:0] o, h;
        p_a.push_back(in_a);
        p_w.push_back(in_w);
        p_rst.push_back(!reset_n);
        n = p_rst.size() - 1;
        #1;
        o = p_level(n, 2, 4'h0, 1'b0);
        h = p_prev(n, 2, 4'h0, 1'b0);
        chk("p2_out",  {3'b0, p2_out},  o);
        chk("p2_rise", {3'b0, p2_rise}, o & ~h & 4'h1);
        chk("p2_fall", {3'b0, p2_fall}, ~o & h & 4'h1);

        o = p_level(n, 3, 4'h0, 1'b1);
        h = p_prev(n, 3, 4'h0, 1'b1);
        chk("p3_out",  p3_out,  o);
        chk("p3_rise", p3_rise, o & ~h);
        chk("p3_fall", p3_fall, ~o & h);

        o = p_level(n, 2, 4'h1, 1'b0);
        h = p_prev(n, 2, 4'h1, 1'b0);
        chk("rv_out",  {3'b0, rv_out},  o);
        chk("rv_rise", {3'b0, rv_rise}, o & ~h & 4'h1);
        chk("rv_fall", {3'b0, rv_fall}, ~o & h & 4'h1);

        // The negedge instance must hold its value across every rising edge.
        if (n_seen) chk("n2_hold_at_pos", {3'b0, n2_out}, {3'b0, n_last_out});

        if (count_en) begin
            p2_rise_cnt += int'(p2_rise);
            p2_fall_cnt += int'(p2_fall);
        end
    end

    // ---------------- compare: negedge domain ----------------
    always @(negedge clk) begin
        int n;
        logic o, h;
        n_a.push_back(in_a);
        n_rst.push_back(!reset_n);
        n = n_rst.size() - 1;
        #1;
        o = n_level(n);
        h = n_prev(n);
        chk("n2_out",  {3'b0, n2_out},  {3'b0, o});
        chk("n2_rise", {3'b0, n2_rise}, {3'b0, o & ~h});
        chk("n2_fall", {3'b0, n2_fall}, {3'b0, ~o & h});
        n_last_out = o;
        n_seen     = 1'b1;
        if (count_en) begin
            n2_rise_cnt += int'(n2_rise);
            n2_fall_cnt += int'(n2_fall);
        end
    end

    // ---------------- driver helpers ----------------
    // Inputs change 2 time units after a rising edge, away from both clock edges.
    task automatic after_pos(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        in_a    = 1'b0;
        in_w    = 4'h0;

        // Reset is held for the first three edges.
        after_pos(3);
        chk("reset_p2_out",  {3'b0, p2_out},  4'h0);
        chk("reset_p2_rise", {3'b0, p2_rise}, 4'h0);
        chk("reset_p3_out",  p3_out,          4'h0);
        chk("reset_rv_out",  {3'b0, rv_out},  4'h1);
        reset_n = 1'b1;
        after_pos(5);

        // Directed 0->1 step driven just after posedge k.
        in_a = 1'b1;
        in_w = 4'hA;
        after_pos(1);   // k+1: sampled into the first stage only
        chk("step_p2_k1", {3'b0, p2_out}, 4'h0);
        chk("step_n2_k1", {3'b0, n2_out}, 4'h0);
        after_pos(1);   // k+2
        chk("step_p2_k2",      {3'b0, p2_out},  4'h1);
        chk("step_p2_rise_k2", {3'b0, p2_rise}, 4'h1);
        chk("step_p2_fall_k2", {3'b0, p2_fall}, 4'h0);
        chk("step_n2_k2",      {3'b0, n2_out},  4'h1);
        chk("step_n2_rise_k2", {3'b0, n2_rise}, 4'h1);
        chk("step_p3_k2",      p3_out,          4'h0);
        after_pos(1);   // k+3
        chk("step_p2_rise_k3", {3'b0, p2_rise}, 4'h0);
        chk("step_p3_k3",      p3_out,          4'hA);
        chk("step_p3_rise_k3", p3_rise,         4'hA);
        after_pos(1);   // k+4
        chk("step_p3_rise_k4", p3_rise,         4'h0);
        chk("step_p3_k4",      p3_out,          4'hA);
        after_pos(3);

        // One-edge reset pulse while the input is steady high.
        reset_n = 1'b0;
        after_pos(1);
        chk("rst_p2_out",  {3'b0, p2_out},  4'h0);
        chk("rst_p2_fall", {3'b0, p2_fall}, 4'h0);
        chk("rst_rv_out",  {3'b0, rv_out},  4'h1);
        reset_n = 1'b1;
        after_pos(1);
        chk("rel_p2_out_1",  {3'b0, p2_out},  4'h0);
        chk("rel_p2_rise_1", {3'b0, p2_rise}, 4'h0);
        chk("rel_rv_out_1",  {3'b0, rv_out},  4'h1);
        after_pos(1);
        chk("rel_p2_out_2",  {3'b0, p2_out},  4'h1);
        chk("rel_p2_rise_2", {3'b0, p2_rise}, 4'h1);
        chk("rel_rv_out_2",  {3'b0, rv_out},  4'h1);
        chk("rel_rv_rise_2", {3'b0, rv_rise}, 4'h0);
        chk("rel_rv_fall_2", {3'b0, rv_fall}, 4'h0);
        after_pos(1);
        chk("rel_p2_rise_3", {3'b0, p2_rise}, 4'h0);

        // Toggle every 3 periods for 100 toggles, starting from a settled 0.
        in_a = 1'b0;
        after_pos(6);
        count_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            in_a = ~in_a;
            after_pos(3);
        end
        after_pos(6);
        count_en = 1'b0;
        chk("toggle_p2_rises", p2_rise_cnt[3:0] ^ 4'(p2_rise_cnt != 50 ? 4'hF : 4'h0),
            p2_rise_cnt == 50 ? p2_rise_cnt[3:0] : ~p2_rise_cnt[3:0]);
        total++;
        if (p2_rise_cnt != 50 || p2_fall_cnt != 50 || n2_rise_cnt != 50 || n2_fall_cnt != 50) begin
            bad++;
            $display("FAIL toggle_pulse_counts actual p2 r=%0d f=%0d n2 r=%0d f=%0d required 50 each",
                     p2_rise_cnt, p2_fall_cnt, n2_rise_cnt, n2_fall_cnt);
        end

        // Randomized levels with occasional resets, checked by the model.
        for (int c = 0; c < 300; c++) begin
            in_a    = 1'($urandom_range(0, 1));
            in_w    = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 15) != 0);
            after_pos(1);
        end
        reset_n = 1'b1;
        after_pos(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ff2_sync
